// File: rtl/decode_pipe.sv
// Y86-64 decode stage: source/destination select, register file, E/M/W forwarding,
// load-use hazard detection and the D->E pipeline register.
module decode_pipe #(
    parameter int WORD_W = 64,
    parameter int NREG   = 15,
    parameter int RSP_ID = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [3:0]        d_rA,
    input  logic [3:0]        d_rB,
    input  logic [WORD_W-1:0] d_valC,
    input  logic [WORD_W-1:0] d_valP,
    input  logic              stall_e,
    input  logic [3:0]        e_dstE,
    input  logic [WORD_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [WORD_W-1:0] M_valE,
    input  logic [WORD_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [WORD_W-1:0] W_valE,
    input  logic [WORD_W-1:0] W_valM,
    output logic              E_valid,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [WORD_W-1:0] E_valC,
    output logic [WORD_W-1:0] E_valA,
    output logic [WORD_W-1:0] E_valB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB,
    output logic              load_use
);

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RSP     = 4'(RSP_ID);
    localparam logic [3:0] I_NOP   = 4'd1;
    localparam logic [3:0] I_MRMOV = 4'd5;
    localparam logic [3:0] I_POP   = 4'd11;

    logic [WORD_W-1:0] r_rf [NREG];

    logic [3:0]        w_srcA, w_srcB, w_dstE, w_dstM;
    logic [WORD_W-1:0] w_valA, w_valB;
    logic              w_load_use;

    logic              r_vld_p1;
    logic [3:0]        r_icode_p1, r_ifun_p1;
    logic [WORD_W-1:0] r_valC_p1, r_valA_p1, r_valB_p1;
    logic [3:0]        r_dstE_p1, r_dstM_p1, r_srcA_p1, r_srcB_p1;

    function automatic logic id_in_rf(input logic [3:0] id);
        return (id != RNONE) && (32'(id) < NREG);
    endfunction

    // First match wins: youngest producer (E) down to the register file.
    function automatic logic [WORD_W-1:0] fwd_sel(input logic [3:0] id);
        if (!id_in_rf(id))  return '0;
        if (id == e_dstE)   return e_valE;
        if (id == M_dstM)   return m_valM;
        if (id == M_dstE)   return M_valE;
        if (id == W_dstM)   return W_valM;
        if (id == W_dstE)   return W_valE;
        return r_rf[id];
    endfunction

    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        if (d_valid) begin
            case (d_icode)
                4'd2, 4'd4, 4'd6, 4'd10: w_srcA = d_rA;
                4'd9, 4'd11:             w_srcA = RSP;
                default:                 w_srcA = RNONE;
            endcase
            case (d_icode)
                4'd4, 4'd5, 4'd6:        w_srcB = d_rB;
                4'd8, 4'd9, 4'd10, 4'd11: w_srcB = RSP;
                default:                 w_srcB = RNONE;
            endcase
            case (d_icode)
                4'd2, 4'd3, 4'd6:        w_dstE = d_rB;
                4'd8, 4'd9, 4'd10, 4'd11: w_dstE = RSP;
                default:                 w_dstE = RNONE;
            endcase
            case (d_icode)
                4'd5, 4'd11:             w_dstM = d_rA;
                default:                 w_dstM = RNONE;
            endcase
        end
    end

    // call and jXX carry the return/fall-through PC in valA instead of a register.
    always_comb begin
        w_valA = fwd_sel(w_srcA);
        w_valB = fwd_sel(w_srcB);
        if (d_icode == 4'd7 || d_icode == 4'd8) begin
            w_valA = d_valP;
        end
    end

    always_comb begin
        w_load_use = d_valid && r_vld_p1
                     && (r_icode_p1 == I_MRMOV || r_icode_p1 == I_POP)
                     && (r_dstM_p1 != RNONE)
                     && (r_dstM_p1 == w_srcA || r_dstM_p1 == w_srcB);
    end

    // Writeback: the M port is applied second so it wins on a shared id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (id_in_rf(W_dstE)) r_rf[W_dstE] <= W_valE;
            if (id_in_rf(W_dstM)) r_rf[W_dstM] <= W_valM;
        end
    end

    // ---- D -> E pipeline register (stage p1) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_icode_p1 <= I_NOP;
            r_ifun_p1  <= 4'd0;
            r_valC_p1  <= '0;
            r_valA_p1  <= '0;
            r_valB_p1  <= '0;
            r_dstE_p1  <= RNONE;
            r_dstM_p1  <= RNONE;
            r_srcA_p1  <= RNONE;
            r_srcB_p1  <= RNONE;
        end else if (stall_e) begin
            r_vld_p1   <= r_vld_p1;
        end else if (w_load_use) begin
            r_vld_p1   <= 1'b0;
            r_icode_p1 <= I_NOP;
            r_ifun_p1  <= 4'd0;
            r_valC_p1  <= '0;
            r_valA_p1  <= '0;
            r_valB_p1  <= '0;
            r_dstE_p1  <= RNONE;
            r_dstM_p1  <= RNONE;
            r_srcA_p1  <= RNONE;
            r_srcB_p1  <= RNONE;
        end else begin
            r_vld_p1   <= d_valid;
            r_icode_p1 <= d_icode;
            r_ifun_p1  <= d_ifun;
            r_valC_p1  <= d_valC;
            r_valA_p1  <= w_valA;
            r_valB_p1  <= w_valB;
            r_dstE_p1  <= w_dstE;
            r_dstM_p1  <= w_dstM;
            r_srcA_p1  <= w_srcA;
            r_srcB_p1  <= w_srcB;
        end
    end

    assign E_valid  = r_vld_p1;
    assign E_icode  = r_icode_p1;
    assign E_ifun   = r_ifun_p1;
    assign E_valC   = r_valC_p1;
    assign E_valA   = r_valA_p1;
    assign E_valB   = r_valB_p1;
    assign E_dstE   = r_dstE_p1;
    assign E_dstM   = r_dstM_p1;
    assign E_srcA   = r_srcA_p1;
    assign E_srcB   = r_srcB_p1;
    assign load_use = w_load_use;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed-vector bench for decode_pipe with hand-computed expectations.
module tb_decode_pipe;

    localparam int WORD_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              d_valid;
    logic [3:0]        d_icode, d_ifun, d_rA, d_rB;
    logic [WORD_W-1:0] d_valC, d_valP;
    logic              stall_e;
    logic [3:0]        e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [WORD_W-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic              E_valid, load_use;
    logic [3:0]        E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [WORD_W-1:0] E_valC, E_valA, E_valB;

    int n_checks = 0;
    int n_fail   = 0;

    decode_pipe #(.WORD_W(WORD_W), .NREG(15), .RSP_ID(4)) dut (
        .clk(clk), .rst(rst),
        .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
        .d_valC(d_valC), .d_valP(d_valP), .stall_e(stall_e),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .load_use(load_use)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
        d_valid = v; d_icode = ic; d_ifun = 4'd0; d_rA = ra; d_rB = rb;
        d_valC = vc; d_valP = vp;
    endtask

    task automatic clr_fwd();
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    endtask

    initial begin
        rst = 1'b1;
        stall_e = 1'b0;
        clr_fwd();
        set_d(1'b0, 4'd1, 4'hF, 4'hF, '0, '0);
        tick(); tick();
        rst = 1'b0;

        // Load an OPq, then assert reset between edges.
        set_d(1'b1, 4'd6, 4'd2, 4'd3, '0, '0);
        tick();
        check("opq_loaded_valid", E_valid, 1);
        check("opq_loaded_dstE", E_dstE, 4'd3);
        rst = 1'b1;
        #1;
        check("rst_valid", E_valid, 0);
        check("rst_icode", E_icode, 4'd1);
        check("rst_dstE", E_dstE, 4'hF);
        check("rst_dstM", E_dstM, 4'hF);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valA", E_valA, 0);
        check("post_rst_valB", E_valB, 0);
        check("post_rst_icode", E_icode, 4'd6);

        // Writeback to r3, then read it back through the register file.
        set_d(1'b0, 4'd6, 4'd2, 4'd3, '0, '0);
        W_dstE = 4'd3; W_valE = 64'h1234;
        tick();
        check("dvalid0_srcA", E_srcA, 4'hF);
        check("dvalid0_valid", E_valid, 0);
        clr_fwd();
        set_d(1'b1, 4'd4, 4'd1, 4'd3, '0, '0);
        tick();
        check("rf_read_valB", E_valB, 64'h1234);
        check("rf_read_srcB", E_srcB, 4'd3);

        // Forward priority on r5.
        e_dstE = 4'd5; e_valE = 64'hA;
        M_dstE = 4'd5; M_valE = 64'hB;
        W_dstE = 4'd5; W_valE = 64'hC;
        set_d(1'b1, 4'd6, 4'd5, 4'd6, '0, '0);
        #1;
        tick();
        check("fwd_e", E_valA, 64'hA);
        e_dstE = 4'hF;
        tick();
        check("fwd_M_valE", E_valA, 64'hB);
        M_dstM = 4'd5; m_valM = 64'hD;
        tick();
        check("fwd_M_valM_over_valE", E_valA, 64'hD);
        clr_fwd();

        // Load-use: mrmovq into r7 followed by OPq reading r7.
        set_d(1'b1, 4'd5, 4'd7, 4'hF, '0, '0);
        tick();
        check("mrmov_icode", E_icode, 4'd5);
        check("mrmov_dstM", E_dstM, 4'd7);
        set_d(1'b1, 4'd6, 4'd7, 4'd3, '0, '0);
        #1;
        check("lu_high", load_use, 1);
        tick();
        check("lu_bubble_valid", E_valid, 0);
        check("lu_bubble_icode", E_icode, 4'd1);
        check("lu_low", load_use, 0);
        M_dstM = 4'd7; m_valM = 64'h77;
        tick();
        check("lu_after_valA", E_valA, 64'h77);
        check("lu_after_valB", E_valB, 64'h1234);
        check("lu_after_icode", E_icode, 4'd6);
        clr_fwd();

        // Stack pointer setup then call / popq.
        set_d(1'b0, 4'd1, 4'hF, 4'hF, '0, '0);
        W_dstE = 4'd4; W_valE = 64'h100;
        tick();
        clr_fwd();
        set_d(1'b1, 4'd8, 4'hF, 4'hF, 64'h200, 64'h40);
        tick();
        check("call_valA", E_valA, 64'h40);
        check("call_valB", E_valB, 64'h100);
        check("call_dstE", E_dstE, 4'd4);
        check("call_valC", E_valC, 64'h200);
        set_d(1'b1, 4'd11, 4'd1, 4'hF, '0, '0);
        tick();
        check("pop_srcA", E_srcA, 4'd4);
        check("pop_srcB", E_srcB, 4'd4);
        check("pop_dstM", E_dstM, 4'd1);

        // Stall for three cycles with changing D inputs.
        stall_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_d(1'b1, 4'd3, 4'hF, 4'(i), 64'(i + 16), '0);
            tick();
            check("stall_icode", E_icode, 4'd11);
            check("stall_dstM", E_dstM, 4'd1);
        end
        // Stall beats a pending load-use; hazard stays visible.
        set_d(1'b1, 4'd6, 4'd1, 4'd2, '0, '0);
        #1;
        check("stall_lu_high", load_use, 1);
        tick();
        check("stall_lu_hold", E_icode, 4'd11);
        check("stall_lu_still", load_use, 1);
        stall_e = 1'b0;
        set_d(1'b1, 4'd3, 4'hF, 4'd2, 64'h55, '0);
        tick();
        check("unstall_icode", E_icode, 4'd3);
        check("unstall_valC", E_valC, 64'h55);
        check("unstall_dstE", E_dstE, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised Y86-64 decode stage with integrated register file, operand forwarding, load-use hazard detection and the D→E pipeline register. It sits between the fetch pipeline register and the execute stage. It selects source and destination registers from icode, reads the register file, and applies forwarding from the E, M and W stages. It inserts bubbles into E when a load-use hazard is found. Compared with the earlier combinational decode, it adds width parametrisation, registered outputs and hazard handling.

## Interface
- WORD_W, 64, data word width
- NREG, 15, architectural registers (ids 0..NREG-1; id 4'hF = RNONE)
- RSP_ID, 4, register id of stack pointer
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- d_valid  in  1  D-stage instruction present
- d_icode, d_ifun, d_rA, d_rB  in  4 each  decoded fetch fields
- d_valC, d_valP  in  WORD_W  constant / next PC
- stall_e  in  1  hold E register (external, e.g. memory stall)
- e_dstE  in  4,  e_valE  in  WORD_W  execute-stage result (combinational, this cycle)
- M_dstE, M_dstM  in  4;  M_valE, m_valM  in  WORD_W  memory-stage results
- W_dstE, W_dstM  in  4;  W_valE, W_valM  in  WORD_W  writeback; also register-file write ports
- E_icode  out  4,  E_dstM  out  4  (also used internally for hazard check)
- E_valid  out  1,  E_ifun  out  4,  E_valC/E_valA/E_valB  out  WORD_W,  E_dstE/E_srcA/E_srcB  out  4
- load_use  out  1  combinational; fetch/D must hold when high

## Operation
- Source/destination select (icode):
  - srcA: rA for 2, 4, 6, 10; RSP_ID for 9, 11; else F.
  - srcB: rB for 4, 5, 6; RSP_ID for 8–11; else F.
  - dstE: rB for 2, 3, 6; RSP_ID for 8–11; else F.
  - dstM: rA for 5, 11; else F.
- d_valid=0 forces all four ids to F.
- Register file:
  - NREG×WORD_W, two combinational read ports.
  - Two write ports, W_dstE/W_valE and W_dstM/W_valM, written at posedge when id≠F and id<NREG.
  - If both write ports target the same id, W_valM wins.
- Forwarding for each operand, first match wins (id≠F):
  1. e_dstE → e_valE
  2. M_dstM → m_valM
  3. M_dstE → M_valE
  4. W_dstM → W_valM
  5. W_dstE → W_valE
  6. register file
- Id F, or id ≥ NREG, yields 0.
- valA = d_valP for icode 7 or 8; else the forwarded srcA value. valB = the forwarded srcB value.
- load_use = d_valid & E_valid & (E_icode==5 | E_icode==11) & E_dstM≠F & (E_dstM==srcA | E_dstM==srcB).
- E register update at posedge, in priority order:
  1. rst → bubble.
  2. stall_e → hold all E outputs.
  3. load_use → bubble.
  4. Else load decoded fields and operands.
- Bubble = E_valid 0, E_icode 1 (nop), E_ifun 0, all ids F, all values 0.

## Timing
- Decode→E latency: 1 cycle. load_use and operand selection are combinational from the same-cycle inputs.
- Reset asserted mid-operation:
  - E register becomes a bubble and the register file is cleared to 0 immediately (async).
  - First load at the first posedge after deassertion.
- W-stage write and D-stage read of the same register in the same cycle: the forwarded W value is used. There is no read-before-write hazard.
- stall_e and load_use together: stall_e wins. load_use stays high, so fetch keeps holding.
- A hazard lasts exactly 1 bubble cycle: the next cycle E holds the bubble (E_valid=0), so load_use drops.

## Test plan
- Reset: assert rst mid-stream → E_valid=0, E_icode=1, E_dstE=E_dstM=F. After release, OPq (icode 6) with rA=2, rB=3 → E_valA=E_valB=0.
- Writeback then read: W_dstE=3, W_valE=0x1234 for 1 cycle. Next cycle rmmovq (icode 4), rB=3 → E_valB=0x1234 one cycle later.
- Forward priority: e_dstE=M_dstE=W_dstE=5 with values 0xA, 0xB, 0xC, and OPq rA=5 → E_valA=0xA. Remove the e match → 0xB.
- Load-use: mrmovq (icode 5) rA=7 enters E. Next D is OPq rA=7.
  - load_use=1 for 1 cycle, E gets a bubble.
  - Next cycle load_use=0 and OPq loads with E_valA=m_valM.
- Stack ops: call (icode 8) with d_valP=0x40 and RSP=0x100 → E_valA=0x40, E_valB=0x100, E_dstE=RSP_ID. popq (icode 11) rA=1 → E_srcA=E_srcB=RSP_ID, E_dstM=1.
- Stall: stall_e=1 for 3 cycles with changing D inputs → E outputs unchanged. Release → the current D instruction loads.
